// File: rtl/alu_pkg.sv
// Shared widths, opcode map, command payload and FSM states for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned DW  = 4;
    localparam int unsigned OPW = 4;
    localparam int unsigned RW  = 8;
    localparam int unsigned CW  = OPW + 2 * DW;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(7);
    localparam logic [OPW-1:0] OP_XNOR = OPW'(8);
    localparam logic [OPW-1:0] OP_NOTA = OPW'(9);
    localparam logic [OPW-1:0] OP_NOTB = OPW'(10);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(12);
    localparam logic [OPW-1:0] OP_LAST = OP_SHR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } cmd_t;

    // A command may reach the ALU only with a defined opcode and a non-zero divisor.
    function automatic logic cmd_legal(cmd_t c);
        logic div_like;
        div_like = (c.op == OP_DIV) || (c.op == OP_MOD);
        return (c.op <= OP_LAST) && !(div_like && (c.b == DW'(0)));
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count; pointers wrap modulo DEPTH.
module cmd_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == LW'(0));
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, screens illegal ones, drives the external ALU and holds its result.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [RW-1:0]  alu_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [RW-1:0]  res_data,
    output logic           res_err,
    output logic [LW-1:0]  fifo_level
);

    state_t        state_q;
    state_t        state_d;
    cmd_t          cmd_in;
    cmd_t          head;
    logic [CW-1:0] head_raw;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          dispatch;
    logic          load_alu;
    logic          cap_alu;
    logic          set_err;
    logic          clr_valid;

    assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign head      = cmd_t'(head_raw);
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (CW'(cmd_in)),
        .pop   (pop),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; a pop from IDLE or a completed DONE dispatches the head.
    always_comb begin
        state_d   = state_q;
        dispatch  = 1'b0;
        pop       = 1'b0;
        load_alu  = 1'b0;
        cap_alu   = 1'b0;
        set_err   = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                dispatch = !fifo_empty;
            end
            EXEC: begin
                cap_alu = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        dispatch = 1'b1;
                    end else begin
                        clr_valid = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (dispatch) begin
            pop = 1'b1;
            if (cmd_legal(head)) begin
                load_alu  = 1'b1;
                clr_valid = 1'b1;
                state_d   = EXEC;
            end else begin
                set_err = 1'b1;
                state_d = DONE;
            end
        end
    end

    // ALU operand registers change only when a legal command is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (load_alu) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
        end
    end

    // Result register: ALU capture, rejection record, or release after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else if (cap_alu) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_err   <= 1'b0;
        end else if (set_err) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_err   <= 1'b1;
        end else if (clr_valid) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front/back-end for the existing 4-bit combinational ALU (13 ops, 8-bit result).
- Buffers operation commands arriving over a valid/ready interface, drives the ALU operand/opcode inputs from registers, and captures the ALU result.
- Presents the captured result on a valid/ready output interface.
- Screens illegal commands (undefined opcode, divide/mod by zero) without issuing them to the ALU.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- DW, 4, operand width (matches ALU a/b)
- OPW, 4, opcode width (matches ALU op_sel)
- RW, 8, result width (matches ALU out)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at clk edge
- cmd_op  in  OPW  opcode (encoding below)
- cmd_a  in  DW  operand A
- cmd_b  in  DW  operand B
- alu_a  out  DW  registered operand to ALU a
- alu_b  out  DW  registered operand to ALU b
- alu_op  out  OPW  registered opcode to ALU op_sel
- alu_out  in  RW  combinational ALU result
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  RW  result
- res_err  out  1  1 = command rejected, res_data = 0
- fifo_level  out  log2(DEPTH)+1  queued command count

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; fifo_level=0; cmd_ready=1 after release; alu_a=alu_b=0; alu_op=0; res_valid=0; res_data=0; res_err=0. Any queued or in-flight command is discarded.
- Opcode map: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 xnor, 9 notA, 10 notB, 11 shl, 12 shr; 13-15 illegal.
- FIFO:
  - cmd_ready = !full (registered-count based).
  - A push while full is impossible, even with a same-cycle pop.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, FIFO non-empty: pop head.
    - Legal command: load alu_a/alu_b/alu_op, go to EXEC.
    - Illegal command (op>=13, or op in {3,4} with b==0): leave alu_* unchanged, set res_data=0, res_err=1, res_valid=1, go to DONE.
  - EXEC: capture alu_out into res_data, res_err=0, res_valid=1, go to DONE. EXEC always lasts exactly 1 cycle.
  - DONE: hold res_* stable while res_valid && !res_ready.
    - On handshake with FIFO non-empty: pop and dispatch as in IDLE on that same edge. res_valid drops for the EXEC cycle (legal command) or stays 1 with the new error result.
    - On handshake with FIFO empty: res_valid=0, go to IDLE.
- Latency: command accepted at edge E0 gives res_valid=1 after E2 (legal) or after E1 (illegal), with FIFO empty and output idle.
- Throughput: one legal result per 2 cycles; illegal commands can complete every cycle.
- Capacity under res_ready=0: DEPTH commands queued plus 1 in the result register. cmd_ready falls after DEPTH+1 accepts.
- alu_* registers change only on a legal pop, so the ALU inputs are stable while a result is held.
- Commands complete strictly in arrival order.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SHR (0-12) and OP_LAST=12;
  - widths DW/OPW/RW;
  - the FSM state enum (IDLE, EXEC, DONE).
- Natural sub-module: cmd_fifo, a parameterised synchronous FIFO (width OPW+2*DW, depth DEPTH) with push, pop, full, empty and level.
- The sequencer FSM plus the legality check stays in the top module.
- The bench connects the existing ALU between alu_a/alu_b/alu_op and alu_out.

Test Plan:
- Reset: rst_n=0 mid-DONE with res_valid=1 and 3 queued commands -> res_valid=0, fifo_level=0, alu_op=0 immediately (asynchronous), before any clk edge.
- Single legal command: op=2, a=6, b=9, res_ready=1 -> res_valid rises 2 cycles after accept, res_data=8'h36, res_err=0, alu_a=6, alu_b=9.
- Illegal commands: op=3, a=6, b=0 -> 1 cycle later res_err=1, res_data=0, alu_* unchanged. op=14 -> same response.
- Backpressure: res_ready=0, cmd_valid=1, ops 0..5 streamed -> exactly 5 accepted (DEPTH=4), cmd_ready=0, fifo_level=4. Then res_ready=1 -> results drain in order 0,1,2,3,4; sixth command is then accepted.
- Ordering and throughput: 13 back-to-back legal ops 0..12 with a=6, b=9, res_ready=1 -> 13 results in order, each matching the ALU model, one every 2 cycles.
- Mixed stream with wrap-around: legal, illegal, legal, repeated 3x with random res_ready -> no drop or duplicate, pointers wrap, res_* stable while res_valid&&!res_ready.
